// File: rtl/rtc_bus_sequencer_if.sv
// Port-side request/response and RTC pad signals of the RTC bus sequencer.
// master = port decoder + pad side, slave = the sequencer itself.
interface rtc_bus_sequencer_if;
  logic       start_wr;
  logic       start_rd;
  logic [7:0] addr_in;
  logic [7:0] wdata_in;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       CS;
  logic       AD;
  logic       RD;
  logic       WR;
  logic [7:0] rdata_out;
  logic       busy;
  logic       done;

  modport master (
    output start_wr, start_rd, addr_in, wdata_in, bus_in,
    input  bus_out, bus_oe, CS, AD, RD, WR,
    input  rdata_out, busy, done
  );

  modport slave (
    input  start_wr, start_rd, addr_in, wdata_in, bus_in,
    output bus_out, bus_oe, CS, AD, RD, WR,
    output rdata_out, busy, done
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Timed address/data bus cycle generator for a multiplexed-bus RTC chip.
// Every non-idle phase lasts T_PHASE cycles; all pins are registered.
module rtc_bus_sequencer #(
  parameter int unsigned T_PHASE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  rtc_bus_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, ADR_SU, ADR_WR, ADR_HLD,
    DAT_SU, DAT_STB, DAT_HLD, RECOVER
  } state_e;

  localparam logic [7:0] PH_LAST = 8'(T_PHASE - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       cs_q, cs_d;
  logic       ad_q, ad_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       oe_q, oe_d;
  logic [7:0] bout_q, bout_d;
  state_e     nxt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    nxt     = IDLE;

    unique case (state_q)
      IDLE:    nxt = ADR_SU;
      ADR_SU:  nxt = ADR_WR;
      ADR_WR:  nxt = ADR_HLD;
      ADR_HLD: nxt = DAT_SU;
      DAT_SU:  nxt = DAT_STB;
      DAT_STB: nxt = DAT_HLD;
      DAT_HLD: nxt = RECOVER;
      RECOVER: nxt = IDLE;
      default: nxt = IDLE;
    endcase

    if (state_q == IDLE) begin
      if (bus.start_wr || bus.start_rd) begin
        state_d = ADR_SU;
        cnt_d   = PH_LAST;
        addr_d  = bus.addr_in;
        wdata_d = bus.wdata_in;
        is_wr_d = bus.start_wr;
      end
    end else if (cnt_q == 8'd0) begin
      state_d = nxt;
      cnt_d   = PH_LAST;
      done_d  = (state_q == RECOVER);
      // Sample on the edge that ends the strobe, RD still low
      if (state_q == DAT_STB && !is_wr_q)
        rdata_d = bus.bus_in;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_comb begin
    cs_d   = 1'b0;
    ad_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    oe_d   = 1'b0;
    bout_d = 8'h00;
    busy_d = (state_d != IDLE);

    unique case (state_d)
      IDLE, RECOVER: begin
        cs_d = 1'b1;
      end
      ADR_SU, ADR_HLD: begin
        ad_d   = 1'b0;
        oe_d   = 1'b1;
        bout_d = addr_d;
      end
      ADR_WR: begin
        ad_d   = 1'b0;
        wr_d   = 1'b0;
        oe_d   = 1'b1;
        bout_d = addr_d;
      end
      DAT_SU, DAT_HLD: begin
        oe_d   = is_wr_d;
        bout_d = wdata_d;
      end
      DAT_STB: begin
        oe_d   = is_wr_d;
        bout_d = wdata_d;
        wr_d   = !is_wr_d;
        rd_d   = is_wr_d;
      end
      default: begin
        cs_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      is_wr_q <= 1'b0;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      ad_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      bout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      ad_q    <= ad_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.CS        = cs_q;
  assign bus.AD        = ad_q;
  assign bus.RD        = rd_q;
  assign bus.WR        = wr_q;
  assign bus.bus_oe    = oe_q;
  assign bus.bus_out   = bout_q;
  assign bus.rdata_out = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: a pin monitor measures each
// bus cycle and checks it against the queued request when done pulses.
module tb_rtc_bus_sequencer;

  localparam int TP = 2;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] r;
  } exp_t;

  logic clk;
  logic reset;
  rtc_bus_sequencer_if bif ();

  rtc_bus_sequencer #(.T_PHASE(TP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vectors;
  int         errs;
  int         done_cnt;
  exp_t       sbq[$];
  logic [7:0] model_rdata;
  logic [7:0] rd_val;

  int         nbusy, wra, wrd, rdl, oed;
  logic [7:0] a_seen, d_seen;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pad model plus per-transaction measurement
  always @(negedge clk) begin
    if (!reset) begin
      nbusy = 0; wra = 0; wrd = 0; rdl = 0; oed = 0;
      bif.bus_in = 8'hFF;
    end else begin
      bif.bus_in = bif.RD ? 8'hFF : rd_val;
      if (bif.busy) nbusy++;
      if (!bif.WR && !bif.AD) begin wra++; a_seen = bif.bus_out; end
      if (!bif.WR && bif.AD)  begin wrd++; d_seen = bif.bus_out; end
      if (!bif.RD) begin
        rdl++;
        chk("rd_vs_oe", {31'd0, bif.bus_oe}, 0);
        chk("rd_vs_wr", {31'd0, bif.WR}, 1);
      end
      if (!bif.CS && bif.AD && bif.bus_oe) oed++;
      if (bif.done) begin
        exp_t e;
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("busy_len", nbusy, 7 * TP);
          chk("addr", {24'd0, a_seen}, {24'd0, e.a});
          chk("wr_adr_w", wra, TP);
          chk("rdata", {24'd0, bif.rdata_out}, {24'd0, e.r});
          if (e.w) begin
            chk("wdata", {24'd0, d_seen}, {24'd0, e.d});
            chk("wr_dat_w", wrd, TP);
            chk("rd_in_wr", rdl, 0);
            chk("oe_dat_wr", oed, 3 * TP);
          end else begin
            chk("wr_in_rd", wrd, 0);
            chk("rd_w", rdl, TP);
            chk("oe_dat_rd", oed, 0);
          end
        end
        nbusy = 0; wra = 0; wrd = 0; rdl = 0; oed = 0;
      end
    end
  end

  // Caller is just past a negedge; returns just after the accepting edge
  task automatic req(input logic w, input logic r,
                     input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] rv);
    exp_t e;
    bif.start_wr = w;
    bif.start_rd = r;
    bif.addr_in  = a;
    bif.wdata_in = d;
    rd_val       = rv;
    e.w = w;
    e.a = a;
    e.d = d;
    if (w) begin
      e.r = model_rdata;
    end else begin
      e.r = rv;
      model_rdata = rv;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    chk("accept_busy", {31'd0, bif.busy}, 1);
    chk("accept_cs", {31'd0, bif.CS}, 0);
    bif.start_wr = 1'b0;
    bif.start_rd = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bif.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic idle_pins(input string tag);
    chk({tag, "_pins"},
        {28'd0, bif.CS, bif.AD, bif.RD, bif.WR}, 32'hF);
    chk({tag, "_oe"}, {31'd0, bif.bus_oe}, 0);
    chk({tag, "_busy"}, {31'd0, bif.busy}, 0);
    chk({tag, "_done"}, {31'd0, bif.done}, 0);
  endtask

  initial begin
    bit hit;
    vectors = 0;
    errs = 0;
    done_cnt = 0;
    model_rdata = 8'h00;
    rd_val = 8'h00;
    bif.start_wr = 1'b0;
    bif.start_rd = 1'b0;
    bif.addr_in = 8'h00;
    bif.wdata_in = 8'h00;
    reset = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idle_pins("reset");
    chk("reset_rdata", {24'd0, bif.rdata_out}, 0);
    chk("reset_bus_out", {24'd0, bif.bus_out}, 0);

    req(1'b1, 1'b0, 8'h21, 8'h45, 8'h00);
    wait_done();

    req(1'b0, 1'b1, 8'h22, 8'h00, 8'h37);
    wait_done();

    // Simultaneous requests: the write must win
    req(1'b1, 1'b1, 8'h30, 8'h5A, 8'h99);
    wait_done();

    req(1'b1, 1'b0, 8'h31, 8'hA5, 8'h00);
    repeat (5) @(negedge clk);
    bif.start_rd = 1'b1;
    @(negedge clk);
    bif.start_rd = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);

    req(1'b1, 1'b0, 8'h40, 8'h11, 8'h00);
    wait_done();
    req(1'b0, 1'b1, 8'h41, 8'h00, 8'hC3);
    wait_done();

    @(negedge clk);
    req(1'b1, 1'b0, 8'h50, 8'h66, 8'h00);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bif.WR && bif.AD) begin
        hit = 1'b1;
        break;
      end
    end
    chk("found_dat_stb", {31'd0, hit}, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle_pins("mid_reset");
    chk("mid_reset_rdata", {24'd0, bif.rdata_out}, 0);
    void'(sbq.pop_front());
    model_rdata = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idle_pins("post_reset");

    req(1'b0, 1'b1, 8'h52, 8'h00, 8'h7E);
    wait_done();
    repeat (5) @(negedge clk);

    chk("done_count", done_cnt, 7);
    chk("queue_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
